three_parallel_crc_checker: RTL and testbench
=============================================

# three_parallel_crc_checker

Receive-side companion to the 3-parallel CRC generator. Consumes a serial codeword (message followed by its CRC) delivered 3 bits per clock, and runs a 3-step-per-cycle LFSR division by the same generator polynomial. At end of frame it presents the recovered message, the final remainder and a pass/fail flag on a valid/ready output register. It also keeps a saturating count of failed frames.

## Interface
- CRC_W, 4: CRC width (degree of generator).
- POLY, 4'b0011: generator low-order coefficients; x^CRC_W term implicit (default x^4+x+1).
- MSG_LEN, 8: message bits per frame; (MSG_LEN+CRC_W) must be a multiple of 3.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  in_data carries a beat.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  3  codeword bits, in_data[2] earliest on the line.
- out_valid  out  1  frame result held.
- out_ready  in  1  downstream takes result.
- msg_out  out  MSG_LEN  recovered message, first received bit at MSB.
- rem_out  out  CRC_W  final remainder.
- crc_ok  out  1  rem_out == 0.
- err_count  out  8  number of failed frames, saturates at 255.

## Operation
- BEATS = (MSG_LEN+CRC_W)/3; default 4. Beat counter 0..BEATS-1.
- Beat accepted when in_valid && in_ready.
- Per accepted beat, bits processed in order in_data[2], [1], [0]. Each bit b: fb = r[CRC_W-1]^b; r = (r<<1) ^ (fb ? POLY : 0). All three steps are combinational within one cycle.
- Message capture: bits with global index < MSG_LEN shift into msg shift register. A beat may straddle the message/CRC boundary; only its message bits are captured.
- States:
  - ACCUM: in_ready=1.
    - On accept of a non-last beat: update r and the counter.
    - On accept of the last beat: load rem_out with the post-beat r, set crc_ok = (post-beat r == 0), and load msg_out. Clear r and the counter. Set out_valid=1 and go to HOLD.
    - If the last beat fails the check and err_count<255, increment err_count in the same cycle.
  - HOLD: in_ready=0. When out_ready=1: out_valid=0, go to ACCUM. msg_out/rem_out/crc_ok keep their values until the next frame completes.
- Reset (any state, mid-frame included): state ACCUM, r=0, counter=0, msg shift register=0, out_valid=0, msg_out=0, rem_out=0, crc_ok=0, err_count=0. A partial frame is discarded.

## Timing
- Frame result visible the cycle after the last beat is accepted (out_valid rises on that edge).
- Back-to-back frames: minimum BEATS+1 cycles per frame when out_ready is held high. The HOLD state always lasts at least 1 cycle.
- in_valid low mid-frame: no state change, LFSR and counter hold.
- in_data is ignored when in_ready=0; in_valid asserted during HOLD is not consumed.
- out_valid is held stable until out_ready is seen; the result registers do not change while out_valid=1.
- err_count increments on the same edge that out_valid rises; saturation at 255 means no wrap.

## Test plan
- Reset, then a good frame: message 8'b10110011, CRC 4'b0100, beats 101,100,110,100 with out_ready=1 → one cycle after 4th beat: out_valid=1, msg_out=8'hB3, rem_out=0, crc_ok=1, err_count=0.
- Corrupted last bit: beats 101,100,110,101 → rem_out=4'b0011, crc_ok=0, err_count=1, msg_out=8'hB3.
- Backpressure: good frame with out_ready=0 for 5 cycles → out_valid stays 1, in_ready=0, outputs stable. Release → out_valid=0 next cycle, in_ready=1.
- Gapped input: in_valid toggles 1,0,1,0… across the good frame → same result as the first case, out_valid one cycle after the final accepted beat.
- Reset mid-frame: 2 beats of the bad frame, reset for 1 cycle, then the full good frame → crc_ok=1, err_count=0.
- Saturation: 256 bad frames → err_count ends at 255, no wrap. Then one good frame → err_count stays 255.

Source files
------------

// File: rtl/three_parallel_crc_checker.sv
// Receive-side 3-bit-per-clock CRC checker: divides the incoming codeword by the
// generator polynomial and presents message, remainder and pass flag per frame.
module three_parallel_crc_checker #(
    parameter int                CRC_W   = 4,
    parameter logic [CRC_W-1:0]  POLY    = 4'b0011,
    parameter int                MSG_LEN = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MSG_LEN-1:0] msg_out,
    output logic [CRC_W-1:0]   rem_out,
    output logic               crc_ok,
    output logic [7:0]         err_count
);

    localparam int BEATS = (MSG_LEN + CRC_W) / 3;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]         state;
    logic [CRC_W-1:0]   r;
    logic [CNT_W-1:0]   cnt;
    logic [MSG_LEN-1:0] msg_sr;
    logic [CRC_W-1:0]   r_nxt;
    logic [MSG_LEN-1:0] msg_nxt;
    logic               accept;
    logic               last_beat;

    // One serial LFSR division step (feedback taken before the shift).
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r_in, input logic b);
        logic fb;
        fb = r_in[CRC_W-1] ^ b;
        return {r_in[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    assign in_ready  = (state == ACCUM);
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == LAST_BEAT);

    // Three chained steps per beat; only bits still inside the message are captured.
    always_comb begin
        r_nxt   = r;
        msg_nxt = msg_sr;
        for (int k = 0; k < 3; k++) begin
            r_nxt = crc_step(r_nxt, in_data[2-k]);
            if (int'(cnt) * 3 + k < MSG_LEN)
                msg_nxt = {msg_nxt[MSG_LEN-2:0], in_data[2-k]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACCUM;
            r         <= '0;
            cnt       <= '0;
            msg_sr    <= '0;
            out_valid <= 1'b0;
            msg_out   <= '0;
            rem_out   <= '0;
            crc_ok    <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (last_beat) begin
                            rem_out   <= r_nxt;
                            crc_ok    <= (r_nxt == '0);
                            msg_out   <= msg_nxt;
                            r         <= '0;
                            cnt       <= '0;
                            msg_sr    <= '0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                            if (r_nxt != '0 && err_count != 8'hFF)
                                err_count <= err_count + 8'd1;
                        end else begin
                            r      <= r_nxt;
                            cnt    <= cnt + CNT_W'(1);
                            msg_sr <= msg_nxt;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_three_parallel_crc_checker.sv
// Bench for three_parallel_crc_checker: fixed vectors, hand-written corner sequences
// and random frames checked against a polynomial long-division model.
module tb_three_parallel_crc_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] msg_out;
    logic [3:0] rem_out;
    logic       crc_ok;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_err = 0;

    three_parallel_crc_checker #(.CRC_W(4), .POLY(4'b0011), .MSG_LEN(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .msg_out(msg_out), .rem_out(rem_out), .crc_ok(crc_ok), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] cw;
        int          gap;
        int          hold;
        logic [7:0]  msg;
        logic [3:0]  rem;
        logic        ok;
    } vec_t;

    // Remainder of a 16-bit polynomial modulo g(x) = x^4 + x + 1.
    function automatic logic [3:0] poly_mod(input logic [15:0] v_in);
        logic [15:0] v;
        v = v_in;
        for (int i = 15; i >= 4; i--)
            if (v[i]) v = v ^ (16'h0013 << (i - 4));
        return v[3:0];
    endfunction

    // Checker remainder is C(x)*x^4 mod g(x); zero exactly for valid codewords.
    function automatic logic [3:0] model_rem(input logic [11:0] cw);
        return poly_mod({cw, 4'b0000});
    endfunction

    function automatic logic [3:0] crc_of(input logic [7:0] m);
        return poly_mod({4'b0000, m, 4'b0000});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left at a falling edge; returns after the beat has been accepted.
    task automatic put_beat(input logic [2:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [11:0] cw, input int gap, input int hold,
                             input logic [7:0] emsg, input logic [3:0] erem, input logic eok);
        logic [11:0] c;
        c = cw;
        out_ready = (hold == 0);
        for (int j = 0; j < 4; j++) begin
            put_beat(c[11-3*j -: 3]);
            if (j < 3)
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk("gap_out_valid", out_valid, 0);
                end
        end
        if (!eok && exp_err < 255) exp_err++;
        chk("out_valid", out_valid, 1);
        chk("msg_out", msg_out, emsg);
        chk("rem_out", rem_out, erem);
        chk("crc_ok", crc_ok, eok);
        chk("err_count", err_count, exp_err);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = 3'b111;
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_msg", msg_out, emsg);
            chk("hold_rem", rem_out, erem);
            chk("hold_err", err_count, exp_err);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    vec_t vecs[6];

    initial begin
        logic [7:0]  m;
        logic [3:0]  c;
        logic [31:0] rnd;
        logic [11:0] cw;
        logic [3:0]  er;

        vecs[0] = '{12'b1011_0011_0100, 0, 0, 8'hB3, 4'h0, 1'b1};
        vecs[1] = '{12'b1011_0011_0101, 0, 0, 8'hB3, 4'h3, 1'b0};
        vecs[2] = '{12'b1011_0011_0100, 0, 5, 8'hB3, 4'h0, 1'b1};
        vecs[3] = '{12'b1011_0011_0100, 1, 0, 8'hB3, 4'h0, 1'b1};
        vecs[4] = '{12'h000,            0, 0, 8'h00, 4'h0, 1'b1};
        vecs[5] = '{12'h001,            2, 1, 8'h00, 4'h3, 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_data = 3'b000; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_msg", msg_out, 0);
        chk("rst_rem", rem_out, 0);
        chk("rst_ok", crc_ok, 0);
        chk("rst_err", err_count, 0);

        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].cw, vecs[i].gap, vecs[i].hold, vecs[i].msg, vecs[i].rem, vecs[i].ok);

        // Reset in the middle of a bad frame discards it and clears the error count.
        put_beat(3'b101);
        put_beat(3'b100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_err = 0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_err", err_count, 0);
        chk("midrst_msg", msg_out, 0);
        run_frame(12'b1011_0011_0100, 0, 0, 8'hB3, 4'h0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rnd = $urandom;
            m   = rnd[7:0];
            c   = rnd[8] ? crc_of(m) : rnd[15:12];
            cw  = {m, c};
            er  = model_rem(cw);
            run_frame(cw, $urandom_range(0, 2), $urandom_range(0, 3), m, er, er == 4'h0);
        end

        for (int i = 0; i < 256; i++)
            run_frame(12'b1011_0011_0101, 0, 0, 8'hB3, 4'h3, 1'b0);
        chk("sat_err", err_count, 255);
        run_frame(12'b1011_0011_0100, 0, 0, 8'hB3, 4'h0, 1'b1);
        chk("sat_after_good", err_count, 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
